// File: rtl/decode_pkg.sv
// Shared decode types: opcode enumeration, packed control bundle
// and the reg_mux / pc_mux encodings used by decode_logic and decode_queue.
package decode_pkg;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_BR     = 4'h1,
      OP_CMP    = 4'h2,
      OP_ADD    = 4'h3,
      OP_SUB    = 4'h4,
      OP_MUL    = 4'h5,
      OP_DIV    = 4'h6,
      OP_LDR    = 4'h7,
      OP_STR    = 4'h8,
      OP_CONST  = 4'h9,
      OP_JMP    = 4'hA,
      OP_RECONV = 4'hB,
      OP_LDS    = 4'hC,
      OP_STS    = 4'hD,
      OP_ILL    = 4'hE,
      OP_RET    = 4'hF
   } opcode_e;

   typedef struct packed {
      logic       reg_we;
      logic       mem_re;
      logic       mem_we;
      logic       nzp_we;
      logic [1:0] reg_mux;
      logic [1:0] arith;
      logic       alu_out;
      logic [1:0] pc_mux;
      logic       smem_re;
      logic       smem_we;
      logic       ret;
      logic       reconv;
      logic       illegal;
   } ctrl_t;

   localparam logic [1:0] REG_MUX_ALU   = 2'b00;
   localparam logic [1:0] REG_MUX_MEM   = 2'b01;
   localparam logic [1:0] REG_MUX_CONST = 2'b10;
   localparam logic [1:0] REG_MUX_SMEM  = 2'b11;

   localparam logic [1:0] PC_MUX_SEQ = 2'd0;
   localparam logic [1:0] PC_MUX_BR  = 2'd1;
   localparam logic [1:0] PC_MUX_JMP = 2'd2;

endpackage

// File: rtl/decode_logic.sv
// Combinational opcode -> ctrl_t mapping, reusable by any front end.
// Ports: opcode (4b in), ctrl (ctrl_t out). Macro: DECODE_QUEUE_ILLEGAL_TRAP_EN.
module decode_logic
   import decode_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (opcode_e'(opcode))
         OP_BR:  ctrl.pc_mux = PC_MUX_BR;
         OP_CMP: begin
            ctrl.alu_out = 1'b1;
            ctrl.nzp_we  = 1'b1;
         end
         OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_mux = REG_MUX_ALU;
            // 2-bit wraparound maps 3..6 onto 0..3
            ctrl.arith   = opcode[1:0] - 2'd3;
         end
         OP_LDR: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_mux = REG_MUX_MEM;
            ctrl.mem_re  = 1'b1;
         end
         OP_STR: ctrl.mem_we = 1'b1;
         OP_CONST: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_mux = REG_MUX_CONST;
         end
         OP_JMP:    ctrl.pc_mux = PC_MUX_JMP;
         OP_RECONV: ctrl.reconv = 1'b1;
         OP_LDS: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_mux = REG_MUX_SMEM;
            ctrl.smem_re = 1'b1;
         end
         OP_STS: ctrl.smem_we = 1'b1;
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
         OP_ILL: ctrl.illegal = 1'b1;
`else
         OP_ILL: ctrl.illegal = 1'b0;
`endif
         OP_RET: ctrl.ret = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// Instruction decoder feeding a DEPTH-entry FIFO of decoded micro-ops.
// Ports: clk, reset (sync, active-high), flush, in_valid/in_ready/in_instr,
// out_valid/out_ready, out_rd/rs/rt/nzp/imm/ctrl, count, illegal_seen.
// Macro: DECODE_QUEUE_ILLEGAL_TRAP_EN enables the sticky illegal-opcode flag.
module decode_queue
   import decode_pkg::*;
#(
   parameter int INSTR_W    = 16,
   parameter int REG_ADDR_W = 4,
   parameter int IMM_W      = 8,
   parameter int DEPTH      = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [REG_ADDR_W-1:0]      out_rd,
   output logic [REG_ADDR_W-1:0]      out_rs,
   output logic [REG_ADDR_W-1:0]      out_rt,
   output logic [2:0]                 out_nzp,
   output logic [IMM_W-1:0]           out_imm,
   output ctrl_t                      out_ctrl,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       illegal_seen
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = REG_ADDR_W;

   logic [3:0]    dec_op;
   logic [RW-1:0] dec_rd;
   logic [RW-1:0] dec_rs;
   logic [RW-1:0] dec_rt;
   logic [IMM_W-1:0] dec_imm;
   ctrl_t         dec_ctrl;

   assign dec_op  = in_instr[INSTR_W-1 -: 4];
   assign dec_rd  = in_instr[INSTR_W-5 -: RW];
   assign dec_rs  = in_instr[INSTR_W-5-RW -: RW];
   assign dec_rt  = in_instr[INSTR_W-5-2*RW -: RW];
   assign dec_imm = in_instr[IMM_W-1:0];

   decode_logic u_decode (
      .opcode (dec_op),
      .ctrl   (dec_ctrl)
   );

   logic [RW-1:0]    rd_q   [DEPTH];
   logic [RW-1:0]    rs_q   [DEPTH];
   logic [RW-1:0]    rt_q   [DEPTH];
   logic [IMM_W-1:0] imm_q  [DEPTH];
   ctrl_t            ctrl_q [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // in_ready depends only on registered occupancy, never on out_ready
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr]   <= dec_rd;
         rs_q[wr_ptr]   <= dec_rs;
         rt_q[wr_ptr]   <= dec_rt;
         imm_q[wr_ptr]  <= dec_imm;
         ctrl_q[wr_ptr] <= dec_ctrl;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   logic [RW-1:0] head_rd;

   assign head_rd  = rd_q[rd_ptr];
   assign out_rd   = out_valid ? head_rd        : '0;
   assign out_rs   = out_valid ? rs_q[rd_ptr]   : '0;
   assign out_rt   = out_valid ? rt_q[rd_ptr]   : '0;
   assign out_nzp  = out_valid ? head_rd[RW-1 -: 3] : 3'b000;
   assign out_imm  = out_valid ? imm_q[rd_ptr]  : '0;
   assign out_ctrl = out_valid ? ctrl_q[rd_ptr] : '0;

`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset || flush)
         illegal_seen <= 1'b0;
      else if (push && dec_ctrl.illegal)
         illegal_seen <= 1'b1;
   end
`else
   assign illegal_seen = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Randomized self-checking bench for decode_queue against a queue-based
// reference model; directed scenarios first, then random traffic.
module tb_decode_queue;
   import decode_pkg::*;

   localparam int INSTR_W    = 16;
   localparam int REG_ADDR_W = 4;
   localparam int IMM_W      = 8;
   localparam int DEPTH      = 2;
   localparam int CW         = $clog2(DEPTH) + 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [INSTR_W-1:0]    in_instr;
   logic                  out_valid;
   logic                  out_ready;
   logic [REG_ADDR_W-1:0] out_rd;
   logic [REG_ADDR_W-1:0] out_rs;
   logic [REG_ADDR_W-1:0] out_rt;
   logic [2:0]            out_nzp;
   logic [IMM_W-1:0]      out_imm;
   ctrl_t                 out_ctrl;
   logic [CW-1:0]         count;
   logic                  illegal_seen;

   decode_queue #(
      .INSTR_W    (INSTR_W),
      .REG_ADDR_W (REG_ADDR_W),
      .IMM_W      (IMM_W),
      .DEPTH      (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_rd       (out_rd),
      .out_rs       (out_rs),
      .out_rt       (out_rt),
      .out_nzp      (out_nzp),
      .out_imm      (out_imm),
      .out_ctrl     (out_ctrl),
      .count        (count),
      .illegal_seen (illegal_seen)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [INSTR_W-1:0] mq[$];
   logic               m_ill;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic ctrl_t ref_ctrl(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         4'h1: c.pc_mux = 2'd1;
         4'h2: begin c.alu_out = 1'b1; c.nzp_we = 1'b1; end
         4'h3, 4'h4, 4'h5, 4'h6: begin
            c.reg_we = 1'b1;
            c.arith  = 2'(op - 4'd3);
         end
         4'h7: begin c.reg_we = 1'b1; c.reg_mux = 2'b01; c.mem_re = 1'b1; end
         4'h8: c.mem_we = 1'b1;
         4'h9: begin c.reg_we = 1'b1; c.reg_mux = 2'b10; end
         4'hA: c.pc_mux = 2'd2;
         4'hB: c.reconv = 1'b1;
         4'hC: begin c.reg_we = 1'b1; c.reg_mux = 2'b11; c.smem_re = 1'b1; end
         4'hD: c.smem_we = 1'b1;
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
         4'hE: c.illegal = 1'b1;
`endif
         4'hF: c.ret = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic check_outputs(input string tag);
      logic [INSTR_W-1:0] h;
      logic [REG_ADDR_W-1:0] erd;
      h = '0;
      if (mq.size() != 0) h = mq[0];
      erd = h[INSTR_W-5 -: REG_ADDR_W];
      chk({tag, ".valid"}, 64'(out_valid), 64'(mq.size() != 0));
      chk({tag, ".count"}, 64'(count), 64'(mq.size()));
      chk({tag, ".ready"}, 64'(in_ready), 64'(mq.size() < DEPTH));
      chk({tag, ".rd"}, 64'(out_rd), 64'(erd));
      chk({tag, ".rs"}, 64'(out_rs),
          64'(h[INSTR_W-5-REG_ADDR_W -: REG_ADDR_W]));
      chk({tag, ".rt"}, 64'(out_rt),
          64'(h[INSTR_W-5-2*REG_ADDR_W -: REG_ADDR_W]));
      chk({tag, ".nzp"}, 64'(out_nzp), 64'(erd[REG_ADDR_W-1 -: 3]));
      chk({tag, ".imm"}, 64'(out_imm), 64'(h[IMM_W-1:0]));
      chk({tag, ".ctrl"}, 64'(out_ctrl),
          64'((mq.size() != 0) ? ref_ctrl(h[INSTR_W-1 -: 4]) : ctrl_t'('0)));
      chk({tag, ".ill"}, 64'(illegal_seen), 64'(m_ill));
   endtask

   // Drive one cycle, advance the model at the edge, check at negedge.
   task automatic step(input string tag, input logic r, input logic f,
                       input logic iv, input logic [INSTR_W-1:0] ins,
                       input logic ordy);
      logic do_push;
      logic do_pop;
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_instr  = ins;
      out_ready = ordy;
      do_pop  = (mq.size() != 0) && ordy;
      do_push = iv && (mq.size() < DEPTH);
      @(posedge clk);
      if (r || f) begin
         mq.delete();
         m_ill = 1'b0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            mq.push_back(ins);
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
            if (ins[INSTR_W-1 -: 4] == 4'hE) m_ill = 1'b1;
`endif
         end
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      ctrl_t c;
      m_ill = 1'b0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_instr = '0; out_ready = 1'b0;
      @(negedge clk);
      step("rst", 1, 0, 0, 16'h0, 0);
      step("rst", 1, 0, 0, 16'h0, 0);
      chk("rst_ready", 64'(in_ready), 64'd1);

      step("add", 0, 0, 1, 16'h3123, 1);
      c = out_ctrl;
      chk("add_valid", 64'(out_valid), 64'd1);
      chk("add_rd", 64'(out_rd), 64'd1);
      chk("add_rs", 64'(out_rs), 64'd2);
      chk("add_rt", 64'(out_rt), 64'd3);
      chk("add_we", 64'(c.reg_we), 64'd1);
      chk("add_mux", 64'(c.reg_mux), 64'd0);
      chk("add_arith", 64'(c.arith), 64'd0);
      step("add_pop", 0, 0, 0, 16'h0, 1);
      chk("add_cnt0", 64'(count), 64'd0);

      for (int op = 0; op < 16; op++) begin
         step("sweep", 0, 0, 1, 16'(op << 12), 1);
      end
      step("lds", 0, 0, 1, 16'hC450, 1);
      c = out_ctrl;
      chk("lds_mux", 64'(c.reg_mux), 64'd3);
      chk("lds_sre", 64'(c.smem_re), 64'd1);
      step("br", 0, 0, 1, 16'h1A07, 1);
      chk("br_nzp", 64'(out_nzp), 64'd5);
      chk("br_imm", 64'(out_imm), 64'h07);
      step("drain", 0, 0, 0, 16'h0, 1);

      step("bp1", 0, 0, 1, 16'h9105, 0);
      step("bp2", 0, 0, 1, 16'h9206, 0);
      chk("bp_full", 64'(in_ready), 64'd0);
      step("bp3", 0, 0, 1, 16'h9307, 0);
      chk("bp_held", 64'(count), 64'd2);
      step("fpp", 0, 0, 1, 16'h9307, 1);
      chk("fpp_cnt", 64'(count), 64'd1);
      chk("fpp_head", 64'(out_imm), 64'h06);
      step("fpp2", 0, 0, 1, 16'h9307, 0);
      chk("fpp2_cnt", 64'(count), 64'd2);
      step("pop6", 0, 0, 0, 16'h0, 1);
      chk("pop6_head", 64'(out_imm), 64'h07);
      step("pop7", 0, 0, 0, 16'h0, 1);
      chk("pop7_empty", 64'(out_valid), 64'd0);

      step("fl1", 0, 0, 1, 16'h3111, 0);
      step("fl2", 0, 0, 1, 16'h4222, 0);
      step("flush", 0, 1, 1, 16'h5333, 0);
      chk("flush_cnt", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_valid), 64'd0);
      step("rs1", 0, 0, 1, 16'h3111, 0);
      step("rs2", 0, 0, 1, 16'h4222, 0);
      step("rstmid", 1, 1, 1, 16'h5333, 0);
      chk("rstmid_cnt", 64'(count), 64'd0);
      chk("rstmid_ctrl", 64'(out_ctrl), 64'd0);

      step("ill", 0, 0, 1, 16'hE000, 0);
      c = out_ctrl;
`ifdef DECODE_QUEUE_ILLEGAL_TRAP_EN
      chk("ill_bit", 64'(c.illegal), 64'd1);
      chk("ill_seen", 64'(illegal_seen), 64'd1);
`else
      chk("ill_nop", 64'(c), 64'd0);
      chk("ill_seen0", 64'(illegal_seen), 64'd0);
`endif
      step("ill_fl", 0, 1, 0, 16'h0, 0);
      chk("ill_clr", 64'(illegal_seen), 64'd0);

      for (int i = 0; i < 3000; i++) begin
         step("rand",
              ($urandom_range(0, 199) == 0),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 9) < 7),
              16'($urandom),
              ($urandom_range(0, 9) < 6));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised instruction decoder with an output buffer of decoded micro-ops. It sits between instruction fetch and the per-core scheduler/execute stage. It accepts raw instructions over a valid/ready handshake, decodes each in one cycle into register fields and control signals, and queues them in a DEPTH-entry FIFO so fetch and execute are decoupled. One instance per core.

## Interface
Parameters:
- INSTR_W, 16, instruction width; must be ≥ 4 + 3*REG_ADDR_W.
- REG_ADDR_W, 4, register address field width.
- IMM_W, 8, immediate width; must be ≤ 2*REG_ADDR_W.
- DEPTH, 2, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all queued entries (branch redirect).
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept.
- in_instr  in  INSTR_W  raw instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_rd / out_rs / out_rt  out  REG_ADDR_W  register fields.
- out_nzp  out  3  branch condition.
- out_imm  out  IMM_W  immediate.
- out_ctrl  out  ctrl_t  packed control bundle.
- count  out  $clog2(DEPTH)+1  occupancy.
- illegal_seen  out  1  sticky illegal-opcode flag; tied 0 without the macro.

## Operation
- Field extraction: opcode = in_instr[INSTR_W-1 -: 4]. rd sits directly below it, then rs, then rt, each REG_ADDR_W wide. imm = in_instr[IMM_W-1:0]. nzp = top 3 bits of the rd field. With defaults: rd [11:8], rs [7:4], rt [3:0], nzp [11:9].
- ctrl_t defaults are all 0. Each opcode sets only the following:
  - 0 NOP: nothing.
  - 1 BRnzp: pc_mux=1.
  - 2 CMP: alu_out=1, nzp_we.
  - 3–6 ADD/SUB/MUL/DIV: reg_we, reg_mux=00, arith = opcode-3.
  - 7 LDR: reg_we, reg_mux=01, mem_re.
  - 8 STR: mem_we.
  - 9 CONST: reg_we, reg_mux=10.
  - A JMP: pc_mux=2.
  - B RECONV: reconv.
  - C LDS: reg_we, reg_mux=11, smem_re.
  - D STS: smem_we.
  - E: undefined (see Configuration).
  - F RET: ret.
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (count < DEPTH). It is registered-only and has no combinational path from out_ready, so a full queue does not accept even when a pop occurs in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- flush: next cycle count=0, pointers=0, out_valid=0. A push in the flush cycle is dropped. flush also clears illegal_seen.
- All out_* fields are driven to 0 whenever out_valid=0.
- Strict FIFO order; no entry is reordered or duplicated.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible with out_valid=1 after edge N when the queue was empty.
- Throughput is 1 instruction per cycle while not full.
- Reset values: in_ready=1, out_valid=0, count=0, every out_* field 0, illegal_seen=0.
- Reset mid-operation discards all entries. reset has priority over flush, and flush has priority over push.

## Configuration
- DECODE_QUEUE_ILLEGAL_TRAP_EN:
  - Defined: opcode E sets ctrl.illegal=1 and is still queued. illegal_seen sets one cycle after that entry is pushed and holds until reset or flush.
  - Undefined: opcode E decodes as NOP, ctrl.illegal is constant 0, and illegal_seen is tied 0.

## Structure
- Package decode_pkg holds:
  - opcode_e enum (4-bit, the values above).
  - ctrl_t packed struct: reg_we, mem_re, mem_we, nzp_we, reg_mux[1:0], arith[1:0], alu_out, pc_mux[1:0], smem_re, smem_we, ret, reconv, illegal.
  - localparams for the reg_mux and pc_mux encodings.
- Sub-module decode_logic: purely combinational opcode → ctrl_t mapping. It is instantiated once in front of the FIFO storage and can be reused by other cores' front ends.

## Test plan
- Single ADD: push 0x3123 into an empty queue, out_ready=1 → next cycle out_valid=1, rd=1, rs=2, rt=3, reg_we=1, reg_mux=00, arith=00; count returns to 0 after the pop.
- Opcode sweep: push 0x0000–0xF000 one at a time → each ctrl_t matches the mapping above; LDS 0xC450 gives reg_mux=11, smem_re=1; BR 0x1A07 gives nzp=101, imm=0x07.
- Backpressure (DEPTH=2): out_ready=0, push 0x9105, 0x9206, 0x9307 → in_ready drops after two pushes and the third is held. Releasing out_ready pops 0x05, 0x06, 0x07 in order.
- Full plus simultaneous push/pop: queue full, out_ready=1, in_valid=1 → the pop occurs and the push is refused that cycle (in_ready=0); the push is accepted the next cycle with count=2.
- Flush/reset: two entries queued, assert flush together with in_valid → next cycle count=0, out_valid=0, the pushed instruction is lost. Repeat with reset and check all reset values.
- Illegal (macro defined): push 0xE000 → entry has illegal=1 and illegal_seen=1 after the push; flush clears illegal_seen. With the macro undefined, the same entry is an all-zero NOP.
